// File: rtl/saber_rgb_pwm.sv
// saber_rgb_pwm: three-channel LED PWM driver with an ignition/retraction brightness ramp.
// Optional plasma flicker in the ON state is compiled in when SABER_FLICKER_EN is defined.
module saber_rgb_pwm #(
  parameter int PRESCALE  = 1,
  parameter int RAMP_STEP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] Ri,
  input  logic [7:0] Gi,
  input  logic [7:0] Bi,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic       frame_start,
  output logic       busy,
  output logic       lit
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);
  localparam logic [8:0] STEP_C = 9'(RAMP_STEP);

  localparam logic [1:0] S_OFF     = 2'd0;
  localparam logic [1:0] S_IGNITE  = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_RETRACT = 2'd3;

  logic [PW-1:0] presc_r;
  logic [7:0]    pwm_cnt_r;
  logic [7:0]    bright_r;
  logic [1:0]    state_r;
  logic [7:0]    duty_red_r, duty_grn_r, duty_blu_r;

  logic          tick_s, fb_s;
  logic [PW-1:0] presc_nx_s;
  logic [7:0]    cnt_nx_s;
  logic [8:0]    up_sum_s;
  logic [7:0]    up_sat_s, dn_sat_s;
  logic [1:0]    state_nx_s, state_d_s;
  logic [7:0]    bright_nx_s, bright_d_s, bright_eff_s;
  logic [7:0]    duty_red_nx_s, duty_grn_nx_s, duty_blu_nx_s;

  // Colour scaled by (brightness+1)/256: bright 255 reproduces the colour exactly.
  function automatic logic [7:0] scale_duty(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, c} * {8'd0, ({1'b0, b} + 9'd1)};
    return prod[15:8];
  endfunction

  assign tick_s     = (presc_r == PS_MAX);
  assign presc_nx_s = tick_s ? {PW{1'b0}} : (presc_r + PW'(1));
  assign cnt_nx_s   = tick_s ? (pwm_cnt_r + 8'd1) : pwm_cnt_r;
  assign fb_s       = tick_s && (pwm_cnt_r == 8'd255);

  // Saturating 9-bit ramp arithmetic keeps brightness inside 0..255.
  assign up_sum_s = {1'b0, bright_r} + STEP_C;
  assign up_sat_s = up_sum_s[8] ? 8'd255 : up_sum_s[7:0];
  assign dn_sat_s = ({1'b0, bright_r} < STEP_C) ? 8'd0 : (bright_r - STEP_C[7:0]);

  // Ignition/retraction step evaluated as if this cycle were a frame boundary.
  always_comb begin
    state_nx_s  = state_r;
    bright_nx_s = bright_r;
    case (state_r)
      S_OFF: begin
        if (en) begin
          state_nx_s  = S_IGNITE;
          bright_nx_s = up_sat_s;
        end else begin
          state_nx_s  = S_OFF;
          bright_nx_s = 8'd0;
        end
      end
      S_IGNITE, S_RETRACT, S_ON: begin
        if (en) begin
          bright_nx_s = up_sat_s;
          state_nx_s  = (up_sat_s == 8'd255) ? S_ON : S_IGNITE;
        end else begin
          bright_nx_s = dn_sat_s;
          state_nx_s  = (dn_sat_s == 8'd0) ? S_OFF : S_RETRACT;
        end
      end
      default: begin
        state_nx_s  = S_OFF;
        bright_nx_s = 8'd0;
      end
    endcase
  end

  assign state_d_s  = fb_s ? state_nx_s : state_r;
  assign bright_d_s = fb_s ? bright_nx_s : bright_r;

`ifdef SABER_FLICKER_EN
  logic [7:0] lfsr_r;
  logic [7:0] lfsr_nx_s;

  assign lfsr_nx_s    = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  assign bright_eff_s = (state_nx_s == S_ON) ? (8'd255 - {4'b0000, lfsr_nx_s[3:0]}) : bright_nx_s;

  // Flicker LFSR advances once per frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= 8'hA5;
    end else if (fb_s) begin
      lfsr_r <= lfsr_nx_s;
    end else begin
      lfsr_r <= lfsr_r;
    end
  end
`else
  assign bright_eff_s = bright_nx_s;
`endif

  assign duty_red_nx_s = fb_s ? scale_duty(Ri, bright_eff_s) : duty_red_r;
  assign duty_grn_nx_s = fb_s ? scale_duty(Gi, bright_eff_s) : duty_grn_r;
  assign duty_blu_nx_s = fb_s ? scale_duty(Bi, bright_eff_s) : duty_blu_r;

  // Counters, FSM, duty latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r     <= {PW{1'b0}};
      pwm_cnt_r   <= 8'd0;
      bright_r    <= 8'd0;
      state_r     <= S_OFF;
      duty_red_r  <= 8'd0;
      duty_grn_r  <= 8'd0;
      duty_blu_r  <= 8'd0;
      pwm_r       <= 1'b0;
      pwm_g       <= 1'b0;
      pwm_b       <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      lit         <= 1'b0;
    end else begin
      presc_r     <= presc_nx_s;
      pwm_cnt_r   <= cnt_nx_s;
      bright_r    <= bright_d_s;
      state_r     <= state_d_s;
      duty_red_r  <= duty_red_nx_s;
      duty_grn_r  <= duty_grn_nx_s;
      duty_blu_r  <= duty_blu_nx_s;
      pwm_r       <= (cnt_nx_s < duty_red_nx_s);
      pwm_g       <= (cnt_nx_s < duty_grn_nx_s);
      pwm_b       <= (cnt_nx_s < duty_blu_nx_s);
      frame_start <= fb_s;
      busy        <= (state_d_s == S_IGNITE) || (state_d_s == S_RETRACT);
      lit         <= (state_d_s != S_OFF);
    end
  end

endmodule

// File: tb/tb_saber_rgb_pwm.sv
// Self-checking bench for saber_rgb_pwm: frame-level reference model plus directed checks.
module tb_saber_rgb_pwm;
  localparam int P    = 1;
  localparam int STEP = 8;
  localparam int FR   = 256 * P;
  localparam int M_OFF = 0, M_IGN = 1, M_ON = 2, M_RET = 3;

  logic clk = 1'b0;
  logic rst_n, en;
  logic [7:0] ri, gi, bi;
  logic pwm_r, pwm_g, pwm_b, frame_start, busy, lit;

  int tests = 0;
  int fails = 0;
  int k, m_st, m_b, m_dr, m_dg, m_db, m_lfsr;

  saber_rgb_pwm #(.PRESCALE(P), .RAMP_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .Ri(ri), .Gi(gi), .Bi(bi),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .frame_start(frame_start), .busy(busy), .lit(lit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int duty(input int c, input int br);
    return (c * (br + 1)) / 256;
  endfunction

  task automatic model_reset();
    k = 0; m_st = M_OFF; m_b = 0;
    m_dr = 0; m_dg = 0; m_db = 0;
    m_lfsr = 8'hA5;
  endtask

  // Frame-boundary behaviour straight from the ramp rules.
  task automatic model_fb();
    int eff;
    if (m_st == M_OFF) begin
      if (en) begin m_b = (STEP > 255) ? 255 : STEP; m_st = M_IGN; end
    end else if (m_st == M_ON && en) begin
      m_b = 255;
    end else if (en) begin
      m_b = (m_b + STEP > 255) ? 255 : m_b + STEP;
      m_st = (m_b == 255) ? M_ON : M_IGN;
    end else begin
      m_b = (m_b - STEP < 0) ? 0 : m_b - STEP;
      m_st = (m_b == 0) ? M_OFF : M_RET;
    end
    eff = m_b;
`ifdef SABER_FLICKER_EN
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
    if (m_st == M_ON) eff = 255 - (m_lfsr & 15);
`endif
    m_dr = duty(ri, eff); m_dg = duty(gi, eff); m_db = duty(bi, eff);
  endtask

  // One clock: advance the model, then compare every output a little after the edge.
  task automatic cycle();
    int pc;
    int expv, obsv;
    @(posedge clk);
    k++;
    if (k % FR == 0) model_fb();
    #1;
    pc = (k / P) % 256;
    expv = ((pc < m_dr) ? 32 : 0) + ((pc < m_dg) ? 16 : 0) + ((pc < m_db) ? 8 : 0)
         + ((k % FR == 0) ? 4 : 0) + ((m_st == M_IGN || m_st == M_RET) ? 2 : 0)
         + ((m_st != M_OFF) ? 1 : 0);
    obsv = 32'({pwm_r, pwm_g, pwm_b, frame_start, busy, lit});
    chk($sformatf("cyc%0d_outs", k), obsv, expv);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic sync_frame();
    int guard = 0;
    while (k % FR != 0 && guard < FR) begin cycle(); guard++; end
    chk("sync_frame_bound", int'(k % FR == 0), 1);
  endtask

  task automatic frames(input int n);
    repeat (n) begin cycle(); sync_frame(); end
  endtask

  // Counts high cycles over one frame, starting from the current (first-of-frame) sample.
  task automatic count_frame(output int hr, output int hg, output int hb, output int fs);
    hr = int'(pwm_r); hg = int'(pwm_g); hb = int'(pwm_b); fs = int'(frame_start);
    repeat (FR - 1) begin
      cycle();
      hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b); fs += int'(frame_start);
    end
  endtask

  initial begin
    int hr, hg, hb, fs, h, r;
    rst_n = 1'b0; en = 1'b1; ri = 8'd255; gi = 8'd255; bi = 8'd255;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm", 32'({pwm_r, pwm_g, pwm_b}), 0);
    chk("rst_status", 32'({frame_start, busy, lit}), 0);

    // Ignition ramp with a fixed colour.
    gi = 8'd40; bi = 8'd200;
    @(negedge clk); rst_n = 1'b1;
    run(FR);
    count_frame(hr, hg, hb, fs);
    chk("ign_frame1_r", hr, 8);
    chk("ign_frame1_b", hb, (200 * 9) / 256);
    run(31 * FR - k);
    chk("ign_busy_fb31", int'(busy), 1);
    run(FR);
    chk("ign_busy_fb32", int'(busy), 0);
    chk("ign_lit_fb32", int'(lit), 1);

    // Full-on duty and frame period.
    run(37);
    ri = 8'd128; gi = 8'd0; bi = 8'd255;
    frames(2);
    count_frame(hr, hg, hb, fs);
    chk("on_r_128", hr, 128);
    chk("on_g_0", hg, 0);
    chk("on_b_255", hb, 255);
    chk("on_fs_once", fs, 1);
    cycle();
    chk("on_fs_period", int'(frame_start), 1);

    // Full retraction to OFF.
    en = 1'b0;
    run(33 * FR);
    chk("ret_lit_off", int'(lit), 0);
    chk("ret_busy_off", int'(busy), 0);

    // Abort ignition at brightness 64.
    ri = 8'd255; en = 1'b1;
    frames(8);
    count_frame(hr, hg, hb, fs);
    chk("abort_at64_r", hr, 64);
    chk("abort_at64_busy", int'(busy), 1);
    en = 1'b0;
    cycle();
    count_frame(hr, hg, hb, fs);
    chk("abort_first56_r", hr, 56);
    frames(7);
    chk("abort_lit_off", int'(lit), 0);
    frames(2);
    count_frame(hr, hg, hb, fs);
    chk("abort_dark_r", hr + hg + hb, 0);

    // Mid-frame colour change at pwm_cnt=100.
    en = 1'b1;
    frames(33);
    chk("mid_on_busy", int'(busy), 0);
    h = int'(pwm_r);
    repeat (100) begin cycle(); h += int'(pwm_r); end
    ri = 8'd0;
    repeat (FR - 101) begin cycle(); h += int'(pwm_r); end
    chk("mid_frame_kept", h, 255);
    cycle();
    count_frame(hr, hg, hb, fs);
    chk("mid_next_frame_r", hr, 0);

    // Randomized colours and power toggling against the model.
    repeat (60) begin
      r = $urandom_range(FR - 1, 1);
      run(r);
      ri = 8'($urandom); gi = 8'($urandom); bi = 8'($urandom);
      if ($urandom_range(3, 0) == 0) en = ~en;
      sync_frame();
    end

    // Async reset in the middle of a retraction.
    en = 1'b1; ri = 8'd255; gi = 8'd255; bi = 8'd255;
    frames(34);
    en = 1'b0;
    frames(3);
    run(50);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", 32'({pwm_r, pwm_g, pwm_b}), 0);
    chk("arst_status", 32'({frame_start, busy, lit}), 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    frames(1);
    chk("restart_busy", int'(busy), 1);
    count_frame(hr, hg, hb, fs);
    chk("restart_r", hr, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
